// File: rtl/xgmii2gmii.sv
`default_nettype none
// ============================================================================
// Module      : xgmii2gmii
// Description : Serialises 64-bit XGMII transmit words into a GMII byte
//               stream (lane 0 first) with frame/error decode and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module xgmii2gmii (
    input  logic        gmii_clk,
    input  logic        sys_rst,
    input  logic [7:0]  xgmii_txc,
    input  logic [63:0] xgmii_txd,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd,
    output logic [31:0] stat_frames,
    output logic [15:0] stat_errors
);

    localparam logic [7:0] C_START    = 8'hFB;
    localparam logic [7:0] C_TERM     = 8'hFD;
    localparam logic [7:0] C_IDLE     = 8'h07;
    localparam logic [7:0] C_PREAMBLE = 8'h55;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_txc;
    logic [63:0] r_txd;
    logic        r_full;
    logic [2:0]  r_ptr;

    logic        r_tx_en;
    logic        r_tx_er;
    logic [7:0]  r_gtxd;
    logic [31:0] r_frames;
    logic [15:0] r_errors;

    logic        w_accept;
    logic        w_lane_c;
    logic [7:0]  w_lane_d;
    logic        w_tx_en;
    logic        w_tx_er;
    logic [7:0]  w_gtxd;
    logic        w_frame_inc;
    logic        w_err_inc;

    // A new word may land on the same edge that lane 7 of the old one is used.
    assign in_ready = !r_full || (r_ptr == 3'd7);
    assign w_accept = in_valid && in_ready;
    assign w_lane_c = r_txc[r_ptr];
    assign w_lane_d = r_txd[{r_ptr, 3'b000} +: 8];

    always_ff @(posedge gmii_clk) begin
        if (sys_rst) begin
            r_full <= 1'b0;
            r_ptr  <= 3'd0;
            r_txc  <= 8'h00;
            r_txd  <= 64'h0;
        end else if (w_accept) begin
            r_txc  <= xgmii_txc;
            r_txd  <= xgmii_txd;
            r_ptr  <= 3'd0;
            r_full <= 1'b1;
        end else if (r_full) begin
            r_ptr <= r_ptr + 3'd1;
            if (r_ptr == 3'd7) begin
                r_full <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_en     = 1'b0;
        w_tx_er     = 1'b0;
        w_gtxd      = 8'h00;
        w_frame_inc = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full) begin
                    if (!w_lane_c) begin
                        w_err_inc = 1'b1;
                    end else if (w_lane_d == C_START) begin
                        w_tx_en     = 1'b1;
                        w_gtxd      = C_PREAMBLE;
                        w_state_nxt = ST_FRAME;
                    end
                end
            end
            ST_FRAME: begin
                if (!r_full) begin
                    // Underrun: poison the frame on the wire, then drop the rest.
                    w_tx_en     = 1'b1;
                    w_tx_er     = 1'b1;
                    w_err_inc   = 1'b1;
                    w_state_nxt = ST_DROP;
                end else if (!w_lane_c) begin
                    w_tx_en = 1'b1;
                    w_gtxd  = w_lane_d;
                end else if (w_lane_d == C_TERM) begin
                    w_frame_inc = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_lane_d == C_IDLE) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tx_en   = 1'b1;
                    w_tx_er   = 1'b1;
                    w_gtxd    = w_lane_d;
                    w_err_inc = 1'b1;
                end
            end
            ST_DROP: begin
                if (r_full && w_lane_c && (w_lane_d == C_TERM || w_lane_d == C_IDLE)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge gmii_clk) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_tx_en  <= 1'b0;
            r_tx_er  <= 1'b0;
            r_gtxd   <= 8'h00;
            r_frames <= 32'd0;
            r_errors <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tx_en <= w_tx_en;
            r_tx_er <= w_tx_er;
            r_gtxd  <= w_gtxd;
            if (w_frame_inc) begin
                r_frames <= r_frames + 32'd1;
            end
            if (w_err_inc && (r_errors != 16'hFFFF)) begin
                r_errors <= r_errors + 16'd1;
            end
        end
    end

    assign gmii_tx_en  = r_tx_en;
    assign gmii_tx_er  = r_tx_er;
    assign gmii_txd    = r_gtxd;
    assign stat_frames = r_frames;
    assign stat_errors = r_errors;

endmodule
`default_nettype wire

// File: tb/tb_xgmii2gmii.sv
`default_nettype none
// ============================================================================
// Module      : tb_xgmii2gmii
// Description : Randomised self-checking bench; reference model is a queue of
//               pending lanes feeding a frame-level decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xgmii2gmii;

    logic        gmii_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  xgmii_txc;
    logic [63:0] xgmii_txd;
    logic        in_valid;
    logic        in_ready;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic [7:0]  gmii_txd;
    logic [31:0] stat_frames;
    logic [15:0] stat_errors;

    always #5 gmii_clk = ~gmii_clk;

    xgmii2gmii u_dut (
        .gmii_clk    (gmii_clk),
        .sys_rst     (sys_rst),
        .xgmii_txc   (xgmii_txc),
        .xgmii_txd   (xgmii_txd),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .gmii_txd    (gmii_txd),
        .stat_frames (stat_frames),
        .stat_errors (stat_errors)
    );

    typedef struct packed {
        logic       c;
        logic [7:0] d;
    } lane_t;

    localparam int M_OUT  = 0;
    localparam int M_IN   = 1;
    localparam int M_SKIP = 2;

    lane_t       lanes[$];
    int          m_mode;
    logic        e_en;
    logic        e_er;
    logic [7:0]  e_d;
    logic [31:0] e_frames;
    logic [15:0] e_errs;
    bit          chk_en;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void bump_err();
        if (e_errs != 16'hFFFF) e_errs = e_errs + 16'd1;
    endfunction

    // One clock cycle: check last edge's outputs, drive inputs, advance model.
    task automatic step(input logic rst, input logic v, input logic [7:0] c,
                        input logic [63:0] d, output bit acc);
        bit    ready;
        bit    has;
        lane_t ln;
        lane_t nl;
        @(negedge gmii_clk);
        ready = (lanes.size() <= 1);
        if (chk_en) begin
            check("tx_en",    gmii_tx_en,  e_en);
            check("tx_er",    gmii_tx_er,  e_er);
            check("txd",      gmii_txd,    e_d);
            check("frames",   stat_frames, e_frames);
            check("errors",   stat_errors, e_errs);
            check("in_ready", in_ready,    ready);
        end
        sys_rst   = rst;
        in_valid  = v;
        xgmii_txc = c;
        xgmii_txd = d;
        acc = 1'b0;
        if (rst) begin
            lanes.delete();
            m_mode   = M_OUT;
            e_en     = 1'b0;
            e_er     = 1'b0;
            e_d      = 8'h00;
            e_frames = 32'd0;
            e_errs   = 16'd0;
        end else begin
            acc = v && ready;
            has = (lanes.size() > 0);
            ln  = '0;
            if (has) ln = lanes.pop_front();
            e_en = 1'b0;
            e_er = 1'b0;
            e_d  = 8'h00;
            if (m_mode == M_OUT) begin
                if (has) begin
                    if (!ln.c) bump_err();
                    else if (ln.d == 8'hFB) begin
                        e_en = 1'b1; e_d = 8'h55; m_mode = M_IN;
                    end
                end
            end else if (m_mode == M_IN) begin
                if (!has) begin
                    e_en = 1'b1; e_er = 1'b1; bump_err(); m_mode = M_SKIP;
                end else if (!ln.c) begin
                    e_en = 1'b1; e_d = ln.d;
                end else if (ln.d == 8'hFD) begin
                    e_frames = e_frames + 32'd1; m_mode = M_OUT;
                end else if (ln.d == 8'h07) begin
                    bump_err(); m_mode = M_OUT;
                end else begin
                    e_en = 1'b1; e_er = 1'b1; e_d = ln.d; bump_err();
                end
            end else begin
                if (has && ln.c && (ln.d == 8'hFD || ln.d == 8'h07)) m_mode = M_OUT;
            end
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    nl.c = c[k];
                    nl.d = d[8*k +: 8];
                    lanes.push_back(nl);
                end
            end
        end
        @(posedge gmii_clk);
    endtask

    task automatic send(input logic [7:0] c, input logic [63:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 9 && !acc; i++) step(1'b0, 1'b1, c, d, acc);
        if (!acc) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic gap(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 8'($urandom), {$urandom, $urandom}, acc);
    endtask

    task automatic send_idle();
        send(8'hFF, 64'h0707070707070707);
    endtask

    task automatic send_start();
        send(8'h01, 64'hD5555555555555FB);
    endtask

    task automatic send_data();
        send(8'h00, {$urandom, $urandom});
    endtask

    // /T/ in lane k, data below it, idles above it.
    task automatic send_term(input int k);
        logic [7:0]  c;
        logic [63:0] d;
        d = {$urandom, $urandom};
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == k) begin
                c[i] = 1'b1; d[8*i +: 8] = 8'hFD;
            end else if (i > k) begin
                c[i] = 1'b1; d[8*i +: 8] = 8'h07;
            end
        end
        send(c, d);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc;
        logic [15:0] errs0;
        logic [31:0] frames0;
        logic [7:0]  c;
        logic [63:0] d;
        int          k;

        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        xgmii_txc = 8'h00;
        xgmii_txd = 64'h0;
        chk_en    = 1'b0;
        step(1'b1, 1'b1, 8'hFF, 64'h0, acc);
        chk_en = 1'b1;
        step(1'b1, 1'b1, 8'h00, 64'h0, acc);
        step(1'b1, 1'b0, 8'h00, 64'h0, acc);

        // Idle stream.
        repeat (6) send_idle();

        // Single clean frame.
        send_start();
        repeat (8) send_data();
        send_term(3);
        repeat (2) send_idle();
        #1;
        check("single_frames", stat_frames, 32'd1);
        check("single_errors", stat_errors, 16'd0);

        // Underrun mid-frame, then a clean frame.
        errs0   = e_errs;
        frames0 = e_frames;
        send_start();
        send_data();
        gap(12);
        repeat (2) send_data();
        send_term(5);
        send_start();
        repeat (2) send_data();
        send_term(0);
        send_idle();
        #1;
        check("underrun_errors", stat_errors, errs0 + 16'd1);
        check("underrun_frames", stat_frames, frames0 + 32'd1);

        // Error control byte inside the payload.
        errs0   = e_errs;
        frames0 = e_frames;
        send_start();
        c = 8'h20;
        d = {$urandom, $urandom};
        d[47:40] = 8'hFE;
        send(c, d);
        send_data();
        send_term(0);
        send_idle();
        #1;
        check("errctl_errors", stat_errors, errs0 + 16'd1);
        check("errctl_frames", stat_frames, frames0 + 32'd1);

        // Reset in the middle of a payload, then a fresh frame.
        send_start();
        send_data();
        gap(3);
        step(1'b1, 1'b0, 8'h00, 64'h0, acc);
        #1;
        check("midrst_tx_en", gmii_tx_en, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        send_start();
        repeat (3) send_data();
        send_term(7);
        send_idle();
        #1;
        check("midrst_frames", stat_frames, 32'd1);

        // Randomised traffic.
        for (int f = 0; f < 40; f++) begin
            send_start();
            for (int p = 0; p < int'($urandom_range(1, 6)); p++) begin
                if ($urandom_range(0, 9) == 0) gap($urandom_range(1, 12));
                c = 8'h00;
                d = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) begin
                    k = $urandom_range(0, 7);
                    c[k] = 1'b1;
                    d[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'hFE : 8'hFB;
                end
                send(c, d);
            end
            send_term($urandom_range(0, 7));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                if ($urandom_range(0, 3) == 0) send(8'($urandom), {$urandom, $urandom} & 64'h0F0F0F0F0F0F0F0F);
                else send_idle();
            end
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 10));
        end

        // Stray data while idle drives the error counter into saturation.
        repeat (2) send_idle();
        #1;
        check("stray_mode_idle", gmii_tx_en, 1'b0);
        repeat (8200) send(8'h00, {$urandom, $urandom} | 64'h0101010101010101);
        send_idle();
        #1;
        check("errors_saturated", stat_errors, 16'hFFFF);
        send_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xgmii2gmii.md
# xgmii2gmii

Transmit-direction width converter: accepts 64-bit XGMII-format words (8 lanes, one control bit per lane) and serialises them into a GMII byte stream, lane 0 first. It is the transmit-side counterpart of the GMII-to-XGMII receive path. It sits on the GMII side of the transmit async FIFO, reading first-word-fall-through words and driving the 1G PHY. Frame delimiters and idles are decoded into `gmii_tx_en`/`gmii_tx_er`, and underruns and protocol errors are counted.

## Interface
Parameters: none.

Ports:
- `gmii_clk` in 1 — the single clock for all logic.
- `sys_rst` in 1 — synchronous, active-high reset.
- `xgmii_txc` in 8 — per-lane control flags; bit k belongs to lane k.
- `xgmii_txd` in 64 — lane k is bits [8k+7:8k].
- `in_valid` in 1 — word present on `xgmii_txc`/`xgmii_txd` (FIFO not empty, FWFT).
- `in_ready` out 1 — word accepted this edge when `in_valid && in_ready` (drives FIFO `rd_en`).
- `gmii_tx_en` out 1 — GMII transmit enable.
- `gmii_tx_er` out 1 — GMII transmit error.
- `gmii_txd` out 8 — GMII data.
- `stat_frames` out 32 — count of frames terminated by /T/; wraps.
- `stat_errors` out 16 — error count; saturates at 16'hffff.

## Operation
- **Word buffer.** The block holds one 72-bit word, a `full` flag and a 3-bit lane pointer.
  - `in_ready = !full || ptr == 7` (combinational from registers only).
  - On accept: load the word and set `ptr = 0`, `full = 1`.
  - Otherwise, when `full`: `ptr` increments each cycle, and at `ptr == 7` with no accept, `full` clears.
- **Decode.** Each cycle the current lane (c, d) is decoded into registered outputs. When `!full`, the lane is treated as "no byte".
- **State machine (IDLE, FRAME, DROP).**
  - IDLE:
    - c=1, d=FB (/S/): output `tx_en=1`, `txd=8'h55` (the preamble byte replaced by /S/); go to FRAME.
    - c=1, other values (07 idle and the rest): `tx_en=0`, `txd=0`.
    - c=0 data: discard, `tx_en=0`, `stat_errors++`.
    - No byte: `tx_en=0`.
  - FRAME:
    - c=0: `tx_en=1`, `txd=d`.
    - c=1, d=FD (/T/): `tx_en=0`, `stat_frames++`; go to IDLE.
    - c=1, d=07 (idle without /T/): `tx_en=0`, `stat_errors++`; go to IDLE.
    - c=1, d=FB (second /S/) or any other control (e.g. FE): `tx_en=1`, `tx_er=1`, `txd=d`, `stat_errors++`; stay in FRAME.
    - No byte (underrun): `tx_en=1`, `tx_er=1`, `txd=0`, `stat_errors++`; go to DROP.
  - DROP:
    - `tx_en=0`; consume lanes without output.
    - c=1 with d=FD or 07: go to IDLE (no frame counted).
    - No byte: stay in DROP.
- **Simultaneous events.** In the cycle where `ptr == 7` and a new word is accepted, lane 7 of the old word is decoded; lane 0 of the new word is decoded next cycle. No bubble.
- **Reset.** Reset mid-frame returns to IDLE immediately and discards the buffered word. `in_valid` is not sampled during reset.

## Timing
- **Reset values:**
  - `gmii_tx_en=0`, `gmii_tx_er=0`, `gmii_txd=8'h00`.
  - `stat_frames=0`, `stat_errors=0`.
  - `full=0`, so `in_ready=1` in the first cycle after reset.
- **Latency.** For a word accepted at edge N, lane k appears on GMII outputs after edge N+1+k. Back-to-back words give a continuous byte stream, one word per 8 cycles.
- **`in_ready` rate.** Asserted at most 1 cycle in 8 while streaming. It is asserted continuously while empty.
- **Counter timing.** Counters update on the same edge as the corresponding output byte.
- **Output hold.** The GMII outputs are registered and change only on `gmii_clk` edges.

## Test plan
- **Idle and reset.** Feed words `txc=FF`, `txd=0707070707070707`. Require `tx_en=0`, `tx_er=0` and `in_ready` pulsing once per 8 cycles; all outputs 0 during reset and `in_ready=1` after it.
- **Single frame.**
  - Stimulus: word0 `c=01`, d = FB,55,55,55,55,55,55,D5; 8 data words; final word with /T/ in lane 3 and 07 in lanes 4–7.
  - Required: bytes 55×7, D5 then payload with `tx_en=1`, starting 1 cycle after accept; `tx_en` falls exactly at lane 3; `stat_frames=1`; `stat_errors=0`.
- **Underrun.** Deassert `in_valid` mid-frame. Require one byte `tx_en=1`, `tx_er=1`, then `tx_en=0`, `stat_errors=1`. Subsequent data is discarded until /T/; the next /S/ frame is transmitted cleanly.
- **Error control.** Put FE with c=1 in lane 5 of a payload word. Require `tx_er=1`, `txd=FE` for that one byte, `tx_en` held high, and `stat_errors=1`.
- **Stray data and wrap/saturation.**
  - c=0 bytes while IDLE give `tx_en=0`, and each such byte increments `stat_errors`.
  - Preload `stat_errors` near saturation by stimulus to verify it holds at FFFF.
  - 2^32 frames (forced via abbreviated counter check) wraps `stat_frames` to 0.
- **Reset mid-frame.** Assert `sys_rst` during payload. Require `tx_en=0` on the next edge, state IDLE, and the next frame correct.
